// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point field helpers, flag indices and operand classes
package fp_pkg;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Subnormals (exp==0) are flushed and treated as zero.
    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic man_zero);
        if (exp_zero) return ZERO;
        if (!exp_ones) return NORM;
        return man_zero ? INF : NAN;
    endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// rtl/fp_mult_pipe_if.sv - operand/result handshake bundle for the pipelined multiplier
interface fp_mult_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, flags
    );
endinterface

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - normalise, round-to-nearest-even, range check and pack
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                       sign_i,
    input  logic [EXP_W+1:0]           exp_i,
    input  logic [2*MAN_W+1:0]         prod_i,
    output logic [EXP_W+MAN_W:0]       word_o,
    output logic [3:0]                 flags_o
);
    localparam int P  = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic [P-2:0]   norm;
    logic [EW-1:0]  exp_n;
    logic [EW-1:0]  exp_r;
    logic [MAN_W-1:0] frac;
    logic [MAN_W-1:0] frac_r;
    logic           guard;
    logic           sticky;
    logic           round_up;
    logic           carry;

    always_comb begin
        // Drop the leading one; a product in [2,4) bumps the exponent.
        norm     = prod_i[P-1] ? prod_i[P-2:0] : {prod_i[P-3:0], 1'b0};
        exp_n    = exp_i + {{(EW-1){1'b0}}, prod_i[P-1]};
        frac     = norm[P-2 -: MAN_W];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = guard & (sticky | frac[0]);
        {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        exp_r    = exp_n + {{(EW-1){1'b0}}, carry};

        word_o  = '0;
        flags_o = '0;
        if ($signed(exp_r) >= $signed(EXP_MAX)) begin
            word_o                  = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_o[FLAG_OVERFLOW]  = 1'b1;
            flags_o[FLAG_INEXACT]   = 1'b1;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
            word_o                  = {sign_i, {(EXP_W+MAN_W){1'b0}}};
            flags_o[FLAG_UNDERFLOW] = 1'b1;
            flags_o[FLAG_INEXACT]   = 1'b1;
        end else begin
            word_o                  = {sign_i, exp_r[EXP_W-1:0], frac_r};
            flags_o[FLAG_INEXACT]   = guard | sticky;
        end
    end
endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - three-stage floating-point multiplier with global-stall handshake
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic           clk,
    input  logic           rst,
    fp_mult_pipe_if.slave  bus
);
    localparam int W  = word_w(EXP_W, MAN_W);
    localparam int P  = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] BIAS_X = EW'(bias(EXP_W));
    localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;

    logic          v1_q,  v1_d;
    logic [W-1:0]  a1_q,  a1_d;
    logic [W-1:0]  b1_q,  b1_d;
    fp_class_e     cls_a1_q, cls_a1_d;
    fp_class_e     cls_b1_q, cls_b1_d;

    logic          v2_q,         v2_d;
    logic          sign2_q,      sign2_d;
    logic [EW-1:0] exp2_q,       exp2_d;
    logic [P-1:0]  prod2_q,      prod2_d;
    logic          spec2_q,      spec2_d;
    logic [W-1:0]  spec_word2_q, spec_word2_d;
    logic          inv2_q,       inv2_d;

    logic          out_valid_q,  out_valid_d;
    logic [W-1:0]  out_q,        out_d;
    logic [3:0]    flags_q,      flags_d;

    logic [W-1:0]  rp_word;
    logic [3:0]    rp_flags;

    logic any_nan, any_inf, any_zero;

    // One stall signal freezes every stage, so out/flags hold while blocked.
    assign advance       = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.flags     = flags_q;

    always_comb begin
        v1_d     = bus.in_valid;
        a1_d     = bus.a;
        b1_d     = bus.b;
        cls_a1_d = classify(bus.a[W-2 -: EXP_W] == '0, &bus.a[W-2 -: EXP_W],
                            bus.a[MAN_W-1:0] == '0);
        cls_b1_d = classify(bus.b[W-2 -: EXP_W] == '0, &bus.b[W-2 -: EXP_W],
                            bus.b[MAN_W-1:0] == '0);
    end

    always_comb begin
        any_nan  = (cls_a1_q == NAN)  || (cls_b1_q == NAN);
        any_inf  = (cls_a1_q == INF)  || (cls_b1_q == INF);
        any_zero = (cls_a1_q == ZERO) || (cls_b1_q == ZERO);

        v2_d    = v1_q;
        sign2_d = a1_q[W-1] ^ b1_q[W-1];
        inv2_d  = any_inf && any_zero && !any_nan;
        spec2_d = any_nan || any_inf || any_zero;
        if (any_nan || inv2_d)
            spec_word2_d = QNAN;
        else if (any_inf)
            spec_word2_d = {sign2_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            spec_word2_d = {sign2_d, {(EXP_W+MAN_W){1'b0}}};

        exp2_d  = {2'b00, a1_q[W-2 -: EXP_W]} + {2'b00, b1_q[W-2 -: EXP_W]} - BIAS_X;
        prod2_d = {{(MAN_W+1){1'b0}}, 1'b1, a1_q[MAN_W-1:0]}
                * {{(MAN_W+1){1'b0}}, 1'b1, b1_q[MAN_W-1:0]};
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign_i  (sign2_q),
        .exp_i   (exp2_q),
        .prod_i  (prod2_q),
        .word_o  (rp_word),
        .flags_o (rp_flags)
    );

    always_comb begin
        out_valid_d = v2_q;
        if (spec2_q) begin
            out_d                 = spec_word2_q;
            flags_d               = '0;
            flags_d[FLAG_INVALID] = inv2_q;
        end else begin
            out_d   = rp_word;
            flags_d = rp_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            a1_q         <= '0;
            b1_q         <= '0;
            cls_a1_q     <= ZERO;
            cls_b1_q     <= ZERO;
            v2_q         <= 1'b0;
            sign2_q      <= 1'b0;
            exp2_q       <= '0;
            prod2_q      <= '0;
            spec2_q      <= 1'b0;
            spec_word2_q <= '0;
            inv2_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            flags_q      <= '0;
        end else if (advance) begin
            v1_q         <= v1_d;
            a1_q         <= a1_d;
            b1_q         <= b1_d;
            cls_a1_q     <= cls_a1_d;
            cls_b1_q     <= cls_b1_d;
            v2_q         <= v2_d;
            sign2_q      <= sign2_d;
            exp2_q       <= exp2_d;
            prod2_q      <= prod2_d;
            spec2_q      <= spec2_d;
            spec_word2_q <= spec_word2_d;
            inv2_q       <= inv2_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            flags_q      <= flags_d;
        end
    end
endmodule
